sum_frame_tx: RTL

- Downstream consumer of the registered 8-bit adder sum.
- Buffers each sum word in a small FIFO and sends it out on one pin as an asynchronous serial frame: start, 8 data bits LSB-first, even parity, stop.
- Lets the adder result be read by an off-chip UART-style receiver instead of the 8 parallel outputs.

---
 rtl/sum_frame_tx_if.sv | 11 +
 rtl/sum_frame_tx.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/sum_frame_tx_if.sv
// Sum-word handshake between the adder stage (master) and the serial framer (slave).
interface sum_frame_tx_if #(
    parameter int unsigned DATA_W = 8
);
    logic [DATA_W-1:0] sum_in;
    logic              sum_valid;
    logic              sum_ready;

    modport master (output sum_in, output sum_valid, input sum_ready);
    modport slave  (input sum_in, input sum_valid, output sum_ready);
endinterface

// File: rtl/sum_frame_tx.sv
// Buffers adder sum words in a small FIFO and shifts each one out as an async serial frame:
// start, DATA_W data bits LSB-first, even parity, stop.
module sum_frame_tx #(
    parameter int unsigned DATA_W       = 8,
    parameter int unsigned FIFO_DEPTH   = 4,
    parameter int unsigned CLKS_PER_BIT = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    sum_frame_tx_if.slave                 sum_if,
    output logic                          tx,
    output logic                          tx_busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic [7:0]                    drop_cnt
);
    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned IW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t            state_q, state_d;
    logic [PW:0]       wr_q, wr_d;
    logic [PW:0]       rd_q, rd_d;
    logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
    logic [DATA_W-1:0] shift_q, shift_d;
    logic              par_q, par_d;
    logic [BW-1:0]     bit_q, bit_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic              tx_q, tx_d;
    logic              busy_q, busy_d;
    logic [7:0]        drop_q, drop_d;

    logic [PW:0]       level;
    logic              ready;
    logic              push;
    logic              load;
    logic              bit_last;
    logic              idx_last;
    logic [DATA_W-1:0] head;

    // Extra pointer bit distinguishes full from empty, so the difference is the level.
    assign level     = wr_q - rd_q;
    assign ready     = (level != (PW+1)'(FIFO_DEPTH));
    assign push      = sum_if.sum_valid && ready;
    assign bit_last  = (bit_q == BW'(CLKS_PER_BIT - 1));
    assign idx_last  = (idx_q == IW'(DATA_W - 1));
    assign head      = mem_q[rd_q[PW-1:0]];

    assign sum_if.sum_ready = ready;
    assign fifo_level       = level;
    assign tx               = tx_q;
    assign tx_busy          = busy_q;
    assign drop_cnt         = drop_q;

    always_comb begin
        state_d = state_q;
        wr_d    = wr_q;
        rd_d    = rd_q;
        shift_d = shift_q;
        par_d   = par_q;
        bit_d   = bit_q;
        idx_d   = idx_q;
        drop_d  = drop_q;
        load    = 1'b0;

        case (state_q)
            IDLE: begin
                if (level != '0) load = 1'b1;
            end
            START: begin
                if (bit_last) begin
                    bit_d   = '0;
                    idx_d   = '0;
                    state_d = DATA;
                end else begin
                    bit_d = bit_q + BW'(1);
                end
            end
            DATA: begin
                if (bit_last) begin
                    bit_d   = '0;
                    shift_d = shift_q >> 1;
                    if (idx_last) state_d = PARITY;
                    else          idx_d   = idx_q + IW'(1);
                end else begin
                    bit_d = bit_q + BW'(1);
                end
            end
            PARITY: begin
                if (bit_last) begin
                    bit_d   = '0;
                    state_d = STOP;
                end else begin
                    bit_d = bit_q + BW'(1);
                end
            end
            STOP: begin
                if (bit_last) begin
                    bit_d = '0;
                    if (level != '0) load    = 1'b1;
                    else             state_d = IDLE;
                end else begin
                    bit_d = bit_q + BW'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        if (load) begin
            shift_d = head;
            par_d   = ^head;
            bit_d   = '0;
            idx_d   = '0;
            rd_d    = rd_q + (PW+1)'(1);
            state_d = START;
        end

        // Readiness comes from the registered level, so a same-cycle pop never rescues a push.
        if (push) begin
            wr_d = wr_q + (PW+1)'(1);
        end else if (sum_if.sum_valid && drop_q != 8'hFF) begin
            drop_d = drop_q + 8'd1;
        end

        // Line level is registered from the next state so tx changes on the edge that enters each bit.
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
            PARITY:  tx_d = par_d;
            default: tx_d = 1'b1;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            wr_q    <= '0;
            rd_q    <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            bit_q   <= '0;
            idx_q   <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            drop_q  <= '0;
        end else begin
            state_q <= state_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            bit_q   <= bit_d;
            idx_q   <= idx_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            drop_q  <= drop_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_q[PW-1:0]] <= sum_if.sum_in;
    end
endmodule
